// File: rtl/test_src_pkg.sv
// Shared types and helpers for the multi-channel random-delay test source.
package test_src_pkg;

    // Per-channel sequencing state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } src_state_e;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_MIX  = 16'h1F35;

    // One step of the 16-bit Galois LFSR (shift right, xor taps when lsb set).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Per-channel seed: base mixed with the channel number; zero is not a legal LFSR state.
    function automatic logic [LFSR_W-1:0] chan_seed(input logic [LFSR_W-1:0] base, input int chan);
        logic [31:0]       prod;
        logic [LFSR_W-1:0] s;
        prod = 32'(chan) * 32'(SEED_MIX);
        s    = base ^ prod[LFSR_W-1:0];
        if (s == '0) s = 16'h0001;
        return s;
    endfunction

endpackage

// File: rtl/test_rand_delay_source_chan.sv
// One output channel: message store, replay FSM, delay counter and LFSR.
// Handshake: a message moves when val && rdy are both high on a rising clk;
// msg is held stable while val is high and rdy is low; rdy while val is low is ignored.
module test_rand_delay_source_chan
    import test_src_pkg::*;
#(
    parameter int          W    = 32,
    parameter int          N    = 1024,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         fixed_mode,
    input  logic [7:0]   max_delay,
    input  logic         load_val,
    input  logic [W-1:0] load_msg,
    output logic         load_drop,
    output logic         val,
    input  logic         rdy,
    output logic [W-1:0] msg,
    output logic         done,
    output src_state_e   state
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic [W-1:0]  mem [N];
    logic [CW-1:0] count, count_nxt;
    logic [CW-1:0] idx, idx_nxt;
    logic [7:0]    dly_cnt, dly_nxt;
    logic [15:0]   lfsr;
    src_state_e    state_nxt;
    logic          load_ok;
    logic [8:0]    modulus;
    logic [7:0]    draw;

    // Loads land only while idle and not full; anything else is reported as dropped.
    assign load_ok   = load_val && (state == IDLE) && (count < CW'(N));
    assign load_drop = load_val && !load_ok;

    // Delay drawn in the cycle of a transition; max_delay == 0 always gives zero.
    assign modulus = {1'b0, max_delay} + 9'd1;
    assign draw    = fixed_mode ? max_delay : 8'(lfsr % {7'd0, modulus});

    assign val  = (state == SEND);
    assign done = (state == DONE);
    assign msg  = mem[idx[AW-1:0]];

    // Message store: written at the current fill level, no reset needed.
    always_ff @(posedge clk) begin
        if (load_ok) mem[count[AW-1:0]] <= load_msg;
    end

    // State, counters and free-running LFSR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            idx     <= '0;
            dly_cnt <= '0;
            lfsr    <= SEED;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            idx     <= idx_nxt;
            dly_cnt <= dly_nxt;
            lfsr    <= lfsr_next(lfsr);
        end
    end

    // Next-state logic; a load in the start cycle is counted before deciding.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        dly_nxt   = dly_cnt;
        if (load_ok) count_nxt = count + CW'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    if (count_nxt == '0) begin
                        state_nxt = DONE;
                    end else if (draw == 8'd0) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt = DELAY;
                        dly_nxt   = draw;
                    end
                end
            end
            DELAY: begin
                dly_nxt = dly_cnt - 8'd1;
                if (dly_cnt == 8'd1) state_nxt = SEND;
            end
            SEND: begin
                if (rdy) begin
                    idx_nxt = idx + CW'(1);
                    if (idx + CW'(1) == count) begin
                        state_nxt = DONE;
                    end else if (draw != 8'd0) begin
                        state_nxt = DELAY;
                        dly_nxt   = draw;
                    end
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/test_rand_delay_source_mc.sv
// Multi-channel random-delay test source: load decode, channel array, error pulse.
module test_rand_delay_source_mc
    import test_src_pkg::*;
#(
    parameter int          p_msg_nbits = 32,
    parameter int          p_num_msgs  = 1024,
    parameter int          p_num_chans = 2,
    parameter logic [15:0] p_lfsr_seed = 16'hACE1,
    localparam int         CHW         = (p_num_chans > 1) ? $clog2(p_num_chans) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             fixed_mode,
    input  logic [7:0]                       max_delay,
    input  logic                             load_val,
    input  logic [CHW-1:0]                   load_chan,
    input  logic [p_msg_nbits-1:0]           load_msg,
    output logic                             load_err,
    output logic [p_num_chans-1:0]           val,
    input  logic [p_num_chans-1:0]           rdy,
    output logic [p_num_chans*p_msg_nbits-1:0] msg,
    output logic [p_num_chans-1:0]           done,
    output logic                             all_done,
    output logic [2*p_num_chans-1:0]         dbg_state
);

    logic [p_num_chans-1:0] chan_drop;
    logic                   range_err;

    assign range_err = load_val && (int'(load_chan) >= p_num_chans);
    assign all_done  = &done;

    for (genvar i = 0; i < p_num_chans; i++) begin : g_chan
        localparam logic [15:0] SEED = chan_seed(p_lfsr_seed, i);
        src_state_e st;

        test_rand_delay_source_chan #(
            .W    (p_msg_nbits),
            .N    (p_num_msgs),
            .SEED (SEED)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .fixed_mode (fixed_mode),
            .max_delay  (max_delay),
            .load_val   (load_val && (int'(load_chan) == i)),
            .load_msg   (load_msg),
            .load_drop  (chan_drop[i]),
            .val        (val[i]),
            .rdy        (rdy[i]),
            .msg        (msg[i*p_msg_nbits +: p_msg_nbits]),
            .done       (done[i]),
            .state      (st)
        );

        assign dbg_state[2*i +: 2] = st;
    end

    // Dropped-load pulse, one cycle after the offending load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) load_err <= 1'b0;
        else        load_err <= range_err || (|chan_drop);
    end

endmodule

// File: tb/tb_test_rand_delay_source_mc.sv
// Bench: drives loads/starts/ready, records every cycle, then checks each channel's
// trace against a timeline computed from the delay rules and a reference LFSR.
module tb_test_rand_delay_source_mc;
    import test_src_pkg::*;

    localparam int W    = 32;
    localparam int N    = 128;
    localparam int NCH  = 3;
    localparam int CHW  = 2;
    localparam int HMAX = 8192;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              fixed_mode = 1'b0;
    logic [7:0]        max_delay = 8'd0;
    logic              load_val = 1'b0;
    logic [CHW-1:0]    load_chan = '0;
    logic [W-1:0]      load_msg = '0;
    logic              load_err;
    logic [NCH-1:0]    val;
    logic [NCH-1:0]    rdy = '0;
    logic [NCH*W-1:0]  msg;
    logic [NCH-1:0]    done;
    logic              all_done;
    logic [2*NCH-1:0]  dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [W-1:0] exp_mem [NCH][N];
    int           n_exp   [NCH];
    logic [W-1:0] exp_q[$];

    logic         val_h  [NCH][HMAX];
    logic         rdy_h  [NCH][HMAX];
    logic         done_h [NCH][HMAX];
    logic [W-1:0] msg_h  [NCH][HMAX];
    logic [15:0]  lf_h   [NCH][HMAX];
    logic         le_h   [HMAX];
    logic         ad_h   [HMAX];
    logic [15:0]  m_lfsr [NCH];

    test_rand_delay_source_mc #(
        .p_msg_nbits (W),
        .p_num_msgs  (N),
        .p_num_chans (NCH),
        .p_lfsr_seed (16'hACE1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fixed_mode (fixed_mode),
        .max_delay  (max_delay),
        .load_val   (load_val),
        .load_chan  (load_chan),
        .load_msg   (load_msg),
        .load_err   (load_err),
        .val        (val),
        .rdy        (rdy),
        .msg        (msg),
        .done       (done),
        .all_done   (all_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference LFSR ----------------
    function automatic logic [15:0] ref_seed(input int ch);
        int v;
        v = 32'hACE1 ^ ((ch * 32'h1F35) & 32'hFFFF);
        if (v == 0) v = 1;
        return v[15:0];
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < NCH; i++)
            m_lfsr[i] <= !reset ? ref_seed(i) : ref_step(m_lfsr[i]);
    end

    // ---------------- per-cycle recorder ----------------
    always @(negedge clk) begin
        if (cyc < HMAX) begin
            le_h[cyc] <= load_err;
            ad_h[cyc] <= all_done;
            for (int i = 0; i < NCH; i++) begin
                val_h[i][cyc]  <= val[i];
                rdy_h[i][cyc]  <= rdy[i];
                done_h[i][cyc] <= done[i];
                msg_h[i][cyc]  <= msg[i*W +: W];
                lf_h[i][cyc]   <= m_lfsr[i];
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*NCH-1:0] all_states(input src_state_e s);
        logic [2*NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[2*i +: 2] = s;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; load_val = 1'b0; rdy = '0;
        for (int i = 0; i < NCH; i++) n_exp[i] = 0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic do_load(input int ch, input logic [W-1:0] m, input bit accept);
        load_val  = 1'b1;
        load_chan = CHW'(ch);
        load_msg  = m;
        if (accept) begin
            exp_mem[ch][n_exp[ch]] = m;
            n_exp[ch]++;
        end
        tick();
        load_val = 1'b0;
    endtask

    task automatic do_start(output int s);
        s     = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: rdy always 1; mode 1: random rdy; mode 2: ch1 stalled through s+8
    task automatic run(input int bound, input int mode, input int s);
        for (int k = 0; k < bound && !all_done; k++) begin
            for (int i = 0; i < NCH; i++) begin
                case (mode)
                    1:       rdy[i] = ($urandom_range(0, 3) != 0);
                    2:       rdy[i] = !(i == 1 && cyc <= s + 8);
                    default: rdy[i] = 1'b1;
                endcase
            end
            tick();
        end
        repeat (3) tick();
    endtask

    // Expected timeline: each message is preceded by a delay drawn at the previous
    // decision cycle, val rises d+1 cycles later and stays up until the first ready cycle.
    task automatic check_stream(input int ch, input int s, input int md, input bit fixed);
        int           t, d, rise, tr, end_c;
        logic [W-1:0] m;
        end_c = (cyc < HMAX) ? cyc : HMAX;
        exp_q = {};
        for (int k = 0; k < n_exp[ch]; k++) exp_q.push_back(exp_mem[ch][k]);
        check($sformatf("ch%0d val at start c%0d", ch, s), val_h[ch][s], 0);
        check($sformatf("ch%0d done at start c%0d", ch, s), done_h[ch][s], 0);
        t = s;
        while (exp_q.size() > 0) begin
            m    = exp_q.pop_front();
            d    = fixed ? md : (int'(lf_h[ch][t]) % (md + 1));
            rise = t + d + 1;
            for (int c = t + 1; c < rise && c < end_c; c++)
                check($sformatf("ch%0d val low c%0d", ch, c), val_h[ch][c], 0);
            tr = rise;
            while (tr < end_c && !rdy_h[ch][tr]) tr++;
            check($sformatf("ch%0d transfer in window", ch), 32'(tr < end_c - 1), 1);
            if (tr >= end_c - 1) return;
            for (int c = rise; c <= tr; c++) begin
                check($sformatf("ch%0d val high c%0d", ch, c), val_h[ch][c], 1);
                check($sformatf("ch%0d msg c%0d", ch, c), msg_h[ch][c], m);
            end
            t = tr;
        end
        check($sformatf("ch%0d val after last c%0d", ch, t + 1), val_h[ch][t + 1], 0);
        check($sformatf("ch%0d done rises c%0d", ch, t + 1), done_h[ch][t + 1], 1);
        check($sformatf("ch%0d done held", ch), done_h[ch][end_c - 1], 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, c0, c_full, c_rng, c_ni, errs;
        logic [W-1:0] r;

        // Reset state
        do_reset();
        check("reset val", 32'(val), 0);
        check("reset done", 32'(done), 0);
        check("reset all_done", 32'(all_done), 0);
        check("reset load_err", 32'(load_err), 0);
        check("reset states", 32'(dbg_state), 32'(all_states(IDLE)));

        // Ordering with zero fixed delay; ch1/ch2 empty
        fixed_mode = 1'b1; max_delay = 8'd0;
        do_load(0, 32'h5, 1); do_load(0, 32'hA, 1); do_load(0, 32'hF, 1);
        rdy = '1;
        do_start(s);
        run(50, 0, s);
        for (int i = 0; i < NCH; i++) check_stream(i, s, 0, 1);
        check("ordering all_done", 32'(ad_h[s + 4]), 1);
        check("ordering all_done early", 32'(ad_h[s + 3]), 0);
        // A second start is ignored
        do_start(s);
        tick(); tick();
        check("restart ignored done", 32'(done), 32'((1 << NCH) - 1));
        check("restart ignored val", 32'(val), 0);
        check("done states", 32'(dbg_state), 32'(all_states(DONE)));

        // Fixed delay 3 with a backpressure stall on ch1
        do_reset();
        fixed_mode = 1'b1; max_delay = 8'd3;
        do_load(1, $urandom, 1); do_load(1, $urandom, 1);
        do_start(s);
        run(100, 2, s);
        for (int i = 0; i < NCH; i++) check_stream(i, s, 3, 1);

        // Random delays, random ready
        do_reset();
        fixed_mode = 1'b0; max_delay = 8'd7;
        for (int k = 0; k < 100; k++) do_load(0, $urandom, 1);
        for (int k = 0; k < 30; k++) do_load(1, $urandom, 1);
        do_start(s);
        run(2500, 1, s);
        for (int i = 0; i < NCH; i++) check_stream(i, s, 7, 0);

        // Load errors: full, out of range, not idle; load coinciding with start
        do_reset();
        fixed_mode = 1'b1; max_delay = 8'd0;
        c0 = cyc;
        for (int k = 0; k < N; k++) do_load(0, $urandom, 1);
        c_full = cyc;
        do_load(0, $urandom, 0);
        c_rng = cyc;
        do_load(3, $urandom, 0);
        do_load(1, $urandom, 1); do_load(1, $urandom, 1);
        r = $urandom;
        load_val = 1'b1; load_chan = 2'd2; load_msg = r;
        exp_mem[2][0] = r; n_exp[2] = 1;
        do_start(s);
        load_val = 1'b0;
        c_ni = cyc;
        do_load(1, $urandom, 0);
        run(400, 0, s);
        errs = 0;
        for (int c = c0 + 1; c <= c_full; c++) errs += int'(le_h[c]);
        check("no err while filling", 32'(errs), 0);
        check("err on full", 32'(le_h[c_full + 1]), 1);
        check("err out of range", 32'(le_h[c_rng + 1]), 1);
        check("err pulse ends", 32'(le_h[c_rng + 4]), 0);
        check("err start+load", 32'(le_h[s + 1]), 0);
        check("err not idle", 32'(le_h[c_ni + 1]), 1);
        for (int i = 0; i < NCH; i++) check_stream(i, s, 0, 1);

        // Reset mid-stream
        do_reset();
        fixed_mode = 1'b1; max_delay = 8'd0;
        do_load(0, $urandom, 1); do_load(0, $urandom, 1);
        rdy = '0;
        do_start(s);
        tick(); tick();
        check("stall val ch0", 32'(val), 1);
        check("stall done", 32'(done), 32'((1 << NCH) - 2));
        #3 reset = 1'b0;
        #1;
        check("async reset val", 32'(val), 0);
        check("async reset done", 32'(done), 0);
        check("async reset all_done", 32'(all_done), 0);
        tick(); tick();
        reset = 1'b1;
        do_start(s);
        check("empty after reset done", 32'(done), 32'((1 << NCH) - 1));
        check("empty after reset val", 32'(val), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/test_rand_delay_source_mc.md
Name: test_rand_delay_source_mc

Overview:
Parametrised, synthesizable multi-channel successor to the single-channel random-delay test source used in unit test harnesses such as the GCD host harness. It holds a per-channel message list loaded through a write port and replays each list on its own val/rdy output. Each message is preceded by an LFSR-driven random delay or a fixed delay. The block sits in front of a DUT request port inside a test harness, and can also be placed on FPGA/emulation builds where hierarchical memory loading is unavailable.

Parameters:
p_msg_nbits, 32, message width in bits
p_num_msgs, 1024, message capacity per channel
p_num_chans, 2, number of independent output channels (>=1)
p_lfsr_seed, 16'hACE1, base seed; channel i is seeded with p_lfsr_seed ^ (i*16'h1F35); a zero result is replaced by 16'h0001

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; launches every channel in IDLE
fixed_mode  in  1  1 = every delay equals max_delay; 0 = random delay
max_delay  in  8  delay bound in cycles
load_val  in  1  append load_msg to channel load_chan
load_chan  in  max(1,$clog2(p_num_chans))  target channel
load_msg  in  p_msg_nbits  message to append
load_err  out  1  registered one-cycle pulse: previous load was dropped
val  out  p_num_chans  per-channel valid
rdy  in  p_num_chans  per-channel ready from the consumer
msg  out  p_num_chans*p_msg_nbits  channel i occupies bits [i*W +: W]
done  out  p_num_chans  per-channel list exhausted
all_done  out  1  AND of done

Behaviour:
- Reset (reset==0, asynchronous assert, release synchronous to clk):
  - All channels go to IDLE.
  - count and idx = 0; val, done, all_done, load_err = 0.
  - LFSRs are reloaded with their seeds. Memory contents are don't-care.
- Per-channel state machine IDLE -> DELAY -> SEND -> (DELAY | SEND | DONE):
  - IDLE:
    - load_val with load_chan == i and count < p_num_msgs: write mem[count], count++.
    - start: if count == 0, go to DONE next cycle; otherwise draw the delay d and go to DELAY (d > 0) or SEND (d == 0).
  - DELAY: counter decrements every cycle; at 1, go to SEND. val = 0.
  - SEND:
    - val = 1 and msg = mem[idx]. msg is held stable until val && rdy.
    - On transfer, idx++. If idx+1 == count, go to DONE.
    - Otherwise draw a new d. d == 0 stays in SEND, giving back-to-back transfers (one message per cycle).
  - DONE: done = 1 and val = 0. The state is held until reset. A further start is ignored.
- Delay draw, sampled in the cycle of the transition:
  - fixed_mode == 1: d = max_delay.
  - fixed_mode == 0: d = lfsr_i[15:0] % (max_delay + 1).
  - max_delay == 0 gives d = 0 in both modes.
- LFSR: 16-bit Galois, taps 0xB400. Each channel's LFSR advances every cycle out of reset, independent of state.
- Load errors: load_err pulses the cycle after a dropped load.
  - A load is dropped if the target channel is not IDLE, the target is full (count == p_num_msgs), or load_chan >= p_num_chans.
  - load_val and start in the same cycle: the load is applied first. The message is included and the new count is used for the start decision.
- Latency from start to first val:
  - d == 0: val is high in the cycle after start.
  - Otherwise: d+1 cycles after start.
  - After a transfer with new draw d: val rises d+1 cycles later; d == 0 keeps val high.
- rdy arriving while val == 0 has no effect.
- Channels are fully independent. Stall on one channel never affects another.
- A reset asserted mid-stream drops val combinationally with the asynchronous clear, and the lists must be reloaded.

Decomposition:
- Package test_src_pkg:
  - state enum {IDLE, DELAY, SEND, DONE}
  - LFSR width and tap constant
  - seed-mix constant 16'h1F35
  - function lfsr_next()
- Sub-module test_rand_delay_source_chan: one channel with its memory, count/idx, FSM, delay counter and LFSR.
- The top level decodes load_chan, generates the channel instances, concatenates msg, and ORs the per-channel errors into load_err.

Test Plan:
- Ordering, fixed delay 0: chans=2; load ch0 {0x00000005, 0x0000000A, 0x0000000F}; fixed_mode=1, max_delay=0; rdy=1; start -> ch0 val high 3 consecutive cycles starting 1 cycle after start with msgs 5, A, F; done[0]=1 next cycle; ch1 empty -> done[1]=1 one cycle after start; all_done=1.
- Fixed delay 3: fixed_mode=1, max_delay=3; 2 msgs on ch1 -> val rises 4 cycles after start; second val rises 4 cycles after first transfer; msg constant while val high.
- Random-delay bound: fixed_mode=0, max_delay=7; 100 msgs -> every gap between a transfer and the next val rise is 1..8 cycles; reference LFSR model with seed 0xACE1 matches the delays exactly.
- Backpressure: rdy=0 for 5 cycles while val=1 -> val and msg held; idx advances only on the rdy=1 cycle.
- Load errors: p_num_msgs=4; 5 loads to ch0 -> load_err only after the 5th; a load to ch0 after start -> load_err, count unchanged; load_chan=2 with 2 channels -> load_err.
- Reset mid-stream: reset low during SEND -> val=0 and done=0 immediately; after release, start with no reload -> done=1 the next cycle.
